// File: rtl/addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : addsub_arbiter
// Function : Two requesters share one 16-bit add/sub unit through a
//            round-robin arbiter; one operation in flight (IDLE->EXEC->RESP).
// Revision : 1.0 - initial release
// ============================================================================
module addsub_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    input  logic        sub0,
    input  logic        sub1,
    input  logic        ovf_clr,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic [15:0] sum,
    output logic        ovfl,
    output logic        valid,
    output logic [7:0]  ovf_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic        owner_q;
    logic        last_q;
    logic [15:0] opa_q;
    logic [15:0] opb_q;
    logic        opsub_q;
    logic        gnt0_q;
    logic        gnt1_q;
    logic        done0_q;
    logic        done1_q;
    logic        valid_q;
    logic [15:0] sum_q;
    logic        ovfl_q;
    logic [7:0]  ovf_count_q;

    logic        w_win;
    logic [15:0] w_b_eff;
    logic [15:0] sum_d;
    logic        ovfl_d;
    logic [7:0]  ovf_count_d;

    always_comb begin
        // Contention goes to whichever requester was not served last
        w_win = 1'b0;
        if (req0 && req1) begin
            w_win = ~last_q;
        end else if (req1) begin
            w_win = 1'b1;
        end

        w_b_eff = opsub_q ? ~opb_q : opb_q;
        sum_d   = opa_q + w_b_eff + {15'd0, opsub_q};
        // Signed overflow: equal operand signs producing a different result sign
        ovfl_d  = (opa_q[15] == w_b_eff[15]) && (sum_d[15] != opa_q[15]);

        ovf_count_d = ovf_count_q;
        if (ovf_clr) begin
            ovf_count_d = 8'd0;
        end else if ((state_q == ST_EXEC) && ovfl_d && (ovf_count_q != 8'hFF)) begin
            ovf_count_d = ovf_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            opa_q       <= 16'd0;
            opb_q       <= 16'd0;
            opsub_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            done0_q     <= 1'b0;
            done1_q     <= 1'b0;
            valid_q     <= 1'b0;
            sum_q       <= 16'd0;
            ovfl_q      <= 1'b0;
            ovf_count_q <= 8'd0;
        end else begin
            ovf_count_q <= ovf_count_d;
            case (state_q)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        opa_q   <= w_win ? a1 : a0;
                        opb_q   <= w_win ? b1 : b0;
                        opsub_q <= w_win ? sub1 : sub0;
                        owner_q <= w_win;
                        last_q  <= w_win;
                        gnt0_q  <= ~w_win;
                        gnt1_q  <= w_win;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    sum_q   <= sum_d;
                    ovfl_q  <= ovfl_d;
                    valid_q <= 1'b1;
                    done0_q <= ~owner_q;
                    done1_q <= owner_q;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    valid_q <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    gnt0_q  <= 1'b0;
                    gnt1_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done0_q <= 1'b0;
                    done1_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign valid     = valid_q;
    assign sum       = sum_q;
    assign ovfl      = ovfl_q;
    assign ovf_count = ovf_count_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_arbiter
// Function : Self-checking bench for addsub_arbiter (vector table, corner
//            sequences, randomized transactions against an arithmetic model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_addsub_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] a0 = 16'd0, b0 = 16'd0, a1 = 16'd0, b1 = 16'd0;
    logic        sub0 = 1'b0, sub1 = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        gnt0, gnt1, done0, done1, ovfl, valid;
    logic [15:0] sum;
    logic [7:0]  ovf_count;

    int n_checks = 0;
    int n_errors = 0;
    int exp_cnt  = 0;
    bit exp_last = 1'b1;

    typedef struct {
        bit          who;
        logic [15:0] a;
        logic [15:0] b;
        bit          sub;
        logic [15:0] es;
        bit          eo;
    } vec_t;

    vec_t vt[8];

    addsub_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .sub0(sub0), .sub1(sub1),
        .ovf_clr(ovf_clr),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .sum(sum), .ovfl(ovfl), .valid(valid), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit who, input bit r, input logic [15:0] a, input logic [15:0] b, input bit s);
        if (!who) begin
            req0 = r; a0 = a; b0 = b; sub0 = s;
        end else begin
            req1 = r; a1 = a; b1 = b; sub1 = s;
        end
    endtask

    task automatic set_req(input bit who, input bit r);
        if (!who) req0 = r;
        else      req1 = r;
    endtask

    function automatic void ref_op(input logic [15:0] a, input logic [15:0] b, input bit s,
                                   output logic [15:0] es, output bit eo);
        int r;
        r  = s ? (int'($signed(a)) - int'($signed(b))) : (int'($signed(a)) + int'($signed(b)));
        es = r[15:0];
        eo = (r > 32767) || (r < -32768);
    endfunction

    function automatic int cnt_next(input int c, input bit eo, input bit clr);
        if (clr) return 0;
        if (eo && c < 255) return c + 1;
        return c;
    endfunction

    task automatic do_reset;
        rst = 1'b1;
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_ovfl", ovfl, 0);
        chk("rst_cnt", ovf_count, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt  = 0;
        exp_last = 1'b1;
    endtask

    // Called #1 after an edge with the DUT idle and no request pending.
    task automatic single(input bit who, input logic [15:0] a, input logic [15:0] b, input bit s,
                          input logic [15:0] es, input bit eo);
        drive(who, 1'b1, a, b, s);
        tick;
        chk("one_gnt_own", who ? gnt1 : gnt0, 1);
        chk("one_gnt_oth", who ? gnt0 : gnt1, 0);
        chk("one_valid_exec", valid, 0);
        drive(who, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
        tick;
        exp_cnt = cnt_next(exp_cnt, eo, 1'b0);
        chk("one_done_own", who ? done1 : done0, 1);
        chk("one_done_oth", who ? done0 : done1, 0);
        chk("one_valid", valid, 1);
        chk("one_sum", sum, es);
        chk("one_ovfl", ovfl, eo);
        chk("one_cnt", ovf_count, exp_cnt);
        set_req(who, 1'b0);
        exp_last = who;
        tick;
        chk("one_valid_idle", valid, 0);
        chk("one_done_idle", done0 | done1, 0);
        chk("one_sum_hold", sum, es);
    endtask

    initial begin
        logic [15:0] opa[2], opb[2], es;
        bit          ops[2], pend[2], eo, w, clr;

        vt[0] = '{1'b0, 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0};
        vt[1] = '{1'b1, 16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0};
        vt[2] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1};
        vt[3] = '{1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
        vt[4] = '{1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0};
        vt[5] = '{1'b1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vt[6] = '{1'b0, 16'h0000, 16'h8000, 1'b1, 16'h8000, 1'b1};
        vt[7] = '{1'b1, 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b0};

        #1;
        do_reset;
        tick;

        for (int i = 0; i < 8; i++)
            single(vt[i].who, vt[i].a, vt[i].b, vt[i].sub, vt[i].es, vt[i].eo);

        // Both requesters held high: grants alternate 0,1,0,1 three cycles apart
        do_reset;
        tick;
        drive(1'b0, 1'b1, 16'd1, 16'd2, 1'b0);
        drive(1'b1, 1'b1, 16'd3, 16'd4, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            int ph, own;
            tick;
            ph  = (c - 1) % 3;
            own = ((c - 1) / 3) % 2;
            chk("rr_gnt0", gnt0, (ph == 0 && own == 0));
            chk("rr_gnt1", gnt1, (ph == 0 && own == 1));
            chk("rr_done0", done0, (ph == 1 && own == 0));
            chk("rr_done1", done1, (ph == 1 && own == 1));
        end
        req0 = 1'b0;
        req1 = 1'b0;

        // Reset in the middle of requester 1's EXEC
        tick;
        do_reset;
        tick;
        drive(1'b1, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        tick;
        chk("rx_gnt1", gnt1, 1);
        drive(1'b0, 1'b1, 16'h0005, 16'h0003, 1'b0);
        #2;
        do_reset;
        tick;
        chk("rx_gnt0_first", gnt0, 1);
        chk("rx_gnt1_off", gnt1, 0);
        chk("rx_no_done1", done1, 0);
        tick;
        chk("rx_done0", done0, 1);
        chk("rx_done1_off", done1, 0);
        chk("rx_sum", sum, 16'h0008);
        chk("rx_cnt", ovf_count, 0);
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        chk("rx_idle_done1", done1, 0);

        // Saturation of the overflow counter
        for (int i = 0; i < 256; i++)
            single(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1);
        chk("sat_cnt", ovf_count, 255);

        // Clear coinciding with an overflowing completion
        drive(1'b0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        tick;
        ovf_clr = 1'b1;
        tick;
        ovf_clr = 1'b0;
        exp_cnt = 0;
        chk("clr_cnt", ovf_count, 0);
        chk("clr_ovfl", ovfl, 1);
        req0 = 1'b0;
        tick;

        // Randomized traffic against the arithmetic / round-robin model
        do_reset;
        tick;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int t = 0; t < 200; t++) begin
            for (int r = 0; r < 2; r++) begin
                if (!pend[r] && $urandom_range(0, 2) != 0) begin
                    pend[r] = 1'b1;
                    opa[r]  = 16'($urandom);
                    opb[r]  = 16'($urandom);
                    ops[r]  = 1'($urandom);
                    drive(1'(r), 1'b1, opa[r], opb[r], ops[r]);
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1'b1;
                opa[0]  = 16'($urandom);
                opb[0]  = 16'($urandom);
                ops[0]  = 1'($urandom);
                drive(1'b0, 1'b1, opa[0], opb[0], ops[0]);
            end
            w = (pend[0] && pend[1]) ? ~exp_last : pend[1];
            tick;
            chk("rnd_gnt0", gnt0, (w == 1'b0));
            chk("rnd_gnt1", gnt1, (w == 1'b1));
            ref_op(opa[w], opb[w], ops[w], es, eo);
            drive(w, 1'b1, 16'($urandom), 16'($urandom), 1'($urandom));
            clr = ($urandom_range(0, 15) == 0);
            ovf_clr = clr;
            tick;
            ovf_clr = 1'b0;
            exp_cnt = cnt_next(exp_cnt, eo, clr);
            chk("rnd_done0", done0, (w == 1'b0));
            chk("rnd_done1", done1, (w == 1'b1));
            chk("rnd_valid", valid, 1);
            chk("rnd_sum", sum, es);
            chk("rnd_ovfl", ovfl, eo);
            chk("rnd_cnt", ovf_count, exp_cnt);
            pend[w] = 1'b0;
            set_req(w, 1'b0);
            exp_last = w;
            tick;
            chk("rnd_valid_idle", valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
